load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit between the RV32I core datapath and a variable-latency data memory. It takes the core's memory operation (address from the ALU, store data from rs2, width/sign from funct3) and runs a request/grant/response handshake on the memory side. It stalls the core until the access completes, then returns sign/zero-extended load data for writeback. Misaligned and illegal accesses are flagged without touching memory.

## Interface
- ADDR_W, 32, address width; mem_addr is word-aligned.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- ls_valid  in  1  core presents a load/store this cycle; held until ls_done
- ls_write  in  1  1 = store, 0 = load
- ls_funct3  in  3  RV32I width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- ls_addr  in  ADDR_W  byte address (ALU result)
- ls_wdata  in  32  store data (rs2)
- ls_stall  out  1  core must hold PC and suppress writeback
- ls_done  out  1  one-cycle pulse: operation complete
- ls_rdata  out  32  extended load data; valid only with ls_done on a load, else 0
- ls_misaligned  out  1  pulses with ls_done on a misaligned or illegal access
- mem_req  out  1  request to memory
- mem_we  out  1  write request
- mem_addr  out  ADDR_W  word address, [1:0] = 00
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response (load data or store ack), at least 1 cycle after gnt
- mem_rdata  in  32  load data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
- IDLE: if ls_valid, latch write/funct3/addr/wdata. Go to ERR if the access is misaligned or illegal. Otherwise go to REQ. ls_stall = ls_valid (combinational).
- Misaligned: h/hu with addr[0]=1; w with addr[1:0]≠00.
- Illegal: loads with funct3 011/110/111; stores with funct3 other than 000/001/010.
- REQ: mem_req=1. mem_we, mem_addr, mem_wdata and mem_be come from registers and stay stable until mem_gnt. On mem_gnt, go to WAIT.
- WAIT: mem_req=0. On mem_rvalid, capture the extracted load data and go to DONE. mem_rvalid outside WAIT is ignored.
- DONE: ls_done=1, ls_stall=0, ls_rdata valid. Go to IDLE unconditionally.
- ERR: ls_done=1, ls_misaligned=1, ls_stall=0, ls_rdata=0, no memory access. Go to IDLE.
- Store formatting:
  - sb: wdata={4{b}}, be=0001<<addr[1:0]
  - sh: wdata={2{h}}, be=addr[1]?1100:0011
  - sw: wdata=wdata, be=1111
- Load extraction: select byte/half at addr[1:0]/addr[1]. Sign-extend for b/h; zero-extend for bu/hu; w passes through. mem_be for loads follows the same rule as stores.
- Input changes after the latch cycle are ignored until the FSM returns to IDLE.
- ls_valid high in the same cycle as DONE/ERR is not a new request; the core advances on that edge.

## Timing
- Reset: all outputs 0, state IDLE. This applies from any state; an in-flight request is abandoned and mem_req drops on the next cycle.
- Minimum load/store latency: request in cycle 0 (IDLE), mem_req in cycle 1 (gnt same cycle), rvalid in cycle 2, ls_done in cycle 3. ls_stall is high in cycles 0–2.
- Error latency: ls_done/ls_misaligned in cycle 1; ls_stall high in cycle 0 only.
- Each extra cycle of gnt or rvalid delay adds exactly one stall cycle.
- At most one outstanding memory transaction.
- mem_rvalid arriving in the same cycle as mem_gnt is a protocol violation and is not supported.

## Structure
- lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - FSM state enum (IDLE/REQ/WAIT/DONE/ERR)
  - misalignment/illegal check function
- Sub-module lsu_align (combinational) produces store lane replication, byte enables, and load extraction/extension. The FSM and registers stay in load_store_unit.

## Test plan
- sw addr 0x100, data 0xDEADBEEF, gnt immediate, rvalid next cycle -> mem_addr 0x100, be 1111, wdata 0xDEADBEEF; ls_done in cycle 3; stall in cycles 0–2.
- lb at 0x103 with rdata 0x80112233 -> ls_rdata 0xFFFFFF80; lbu at the same address -> 0x00000080; be 1000.
- lh at 0x102 with rdata 0x8001_2233 -> 0xFFFF8001.
- sh at 0x102 with data 0x0000ABCD -> wdata 0xABCDABCD, be 1100.
- lw at 0x102; lb with funct3 011 -> ls_done+ls_misaligned in cycle 1, mem_req never asserted, ls_rdata 0.
- gnt delayed 3 cycles, rvalid delayed 2 cycles -> mem_req held with stable addr/be/wdata; ls_done exactly 1 cycle after rvalid; stall in cycles 0–6.
- reset low in WAIT -> next cycle IDLE, all outputs 0; a stray rvalid afterwards produces no ls_done.

Source files
------------

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RV32I funct3 width/sign encodings for loads and stores
//   - FSM state encoding used by load_store_unit
//   - access_fault(): flags misaligned or illegal memory operations
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } lsu_state_e;

  // Returns 1 when the operation must not reach memory. Stores only have
  // b/h/w encodings. Loads additionally allow bu/hu.
  function automatic logic access_fault(input logic       write,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_B:  illegal = 1'b0;
      F3_H:  misaligned = addr_lo[0];
      F3_W:  misaligned = (addr_lo != 2'b00);
      F3_BU: illegal = write;
      F3_HU: begin
        illegal    = write;
        misaligned = addr_lo[0];
      end
      default: illegal = 1'b1;
    endcase
    return illegal | misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane steering for the load/store unit.
// Ports:
//   funct3_i      : latched RV32I width/sign field
//   addr_lo_i     : latched byte offset within the word
//   wdata_i       : latched store data (rs2)
//   rdata_i       : raw word returned by memory
//   store_wdata_o : store data replicated across the byte lanes
//   be_o          : byte enables (same rule for loads and stores)
//   load_data_o   : selected and sign/zero-extended load result
// ---------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] store_wdata_o,
  output logic [3:0]  be_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  laneB;
  logic [15:0] laneH;

  // Pick the addressed byte and halfword out of the returned word.
  always_comb begin
    laneB = rdata_i[7:0];
    case (addr_lo_i)
      2'b00: laneB = rdata_i[7:0];
      2'b01: laneB = rdata_i[15:8];
      2'b10: laneB = rdata_i[23:16];
      2'b11: laneB = rdata_i[31:24];
      default: laneB = rdata_i[7:0];
    endcase
    laneH = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // funct3[1:0] encodes the width and funct3[2] selects zero extension.
  // Word accesses and anything unrecognised fall through untouched.
  always_comb begin
    be_o          = 4'b1111;
    store_wdata_o = wdata_i;
    load_data_o   = rdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o          = 4'b0001 << addr_lo_i;
        store_wdata_o = {4{wdata_i[7:0]}};
        load_data_o   = funct3_i[2] ? {24'b0, laneB} : {{24{laneB[7]}}, laneB};
      end
      2'b01: begin
        be_o          = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        store_wdata_o = {2{wdata_i[15:0]}};
        load_data_o   = funct3_i[2] ? {16'b0, laneH} : {{16{laneH[15]}}, laneH};
      end
      default: begin
        be_o          = 4'b1111;
        store_wdata_o = wdata_i;
        load_data_o   = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Multi-cycle load/store unit between the RV32I core and a variable-latency
// data memory using a req/gnt/rvalid handshake. One transaction at a time.
// Core side:
//   ls_valid/ls_write/ls_funct3/ls_addr/ls_wdata : operation from the core
//   ls_stall      : hold PC and suppress writeback
//   ls_done       : one-cycle completion pulse
//   ls_rdata      : extended load data, only non-zero with ls_done on a load
//   ls_misaligned : pulses with ls_done on a misaligned/illegal access
// Memory side:
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : request, stable until mem_gnt
//   mem_gnt       : request accepted
//   mem_rvalid    : response (load data or store ack)
//   mem_rdata     : load data
// clk rising edge; reset is synchronous and active-low.
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ls_valid,
  input  logic              ls_write,
  input  logic [2:0]        ls_funct3,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_stall,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  output logic              ls_misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              write_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic [31:0] storeWdata;
  logic [3:0]  byteEn;
  logic [31:0] loadData;
  logic        fault;
  logic        latch;

  lsu_align u_align (
    .funct3_i      (funct3_q),
    .addr_lo_i     (addr_q[1:0]),
    .wdata_i       (wdata_q),
    .rdata_i       (mem_rdata),
    .store_wdata_o (storeWdata),
    .be_o          (byteEn),
    .load_data_o   (loadData)
  );

  // The fault check looks at the live inputs so the decision is made in
  // the same cycle the operation is latched.
  assign fault = access_fault(ls_write, ls_funct3, ls_addr[1:0]);
  assign latch = (state_q == IDLE) && ls_valid;

  // Next-state logic. DONE and ERR always return to IDLE, so an ls_valid
  // still high during those cycles is never taken as a new request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ls_valid) state_d = fault ? ERR : REQ;
      REQ:  if (mem_gnt) state_d = WAIT;
      WAIT: if (mem_rvalid) state_d = DONE;
      DONE: state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operation capture and load-result capture. The operation is
  // latched only on the IDLE acceptance cycle so later input changes from
  // the core are ignored until the unit is idle again.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'b0;
      rdata_q  <= 32'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        write_q  <= ls_write;
        funct3_q <= ls_funct3;
        addr_q   <= ls_addr;
        wdata_q  <= ls_wdata;
      end
      if ((state_q == WAIT) && mem_rvalid) begin
        rdata_q <= loadData;
      end
    end
  end

  // Memory-side outputs are driven only while requesting, so they read as
  // zero in every other state and right after reset.
  always_comb begin
    mem_req   = (state_q == REQ);
    mem_we    = mem_req & write_q;
    mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_wdata = mem_req ? storeWdata : 32'b0;
    mem_be    = mem_req ? byteEn : 4'b0000;
  end

  // Core-side outputs. Stall is gated by reset so everything reads zero
  // while reset is held, even if the core keeps ls_valid high.
  always_comb begin
    ls_stall      = reset & (((state_q == IDLE) & ls_valid) |
                             (state_q == REQ) | (state_q == WAIT));
    ls_done       = (state_q == DONE) | (state_q == ERR);
    ls_misaligned = (state_q == ERR);
    ls_rdata      = ((state_q == DONE) && !write_q) ? rdata_q : 32'b0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit. Each operation is described once with
// its expected memory request and result; the expected result goes into a
// scoreboard queue when the operation is issued and is popped when ls_done
// is expected. The bench plays the memory, choosing gnt/rvalid timing.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        ls_valid;
  logic        ls_write;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_stall;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        ls_misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t sbQ[$];
  int   nChecks = 0;
  int   nFail   = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .ls_valid      (ls_valid),
    .ls_write      (ls_write),
    .ls_funct3     (ls_funct3),
    .ls_addr       (ls_addr),
    .ls_wdata      (ls_wdata),
    .ls_stall      (ls_stall),
    .ls_done       (ls_done),
    .ls_rdata      (ls_rdata),
    .ls_misaligned (ls_misaligned),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Runs one operation cycle by cycle. Cycle 0 is the IDLE acceptance
  // cycle; gnt comes in cycle 1+gntExtra, rvalid rvLat cycles after gnt,
  // ls_done one cycle after rvalid (or in cycle 1 for a faulting access).
  // After cycle 0 the core inputs are scrambled to show they are ignored.
  task automatic applyStimulus(input string name, input logic wr,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] memData,
                               input int gntExtra, input int rvLat,
                               input logic expErr, input logic [31:0] expRd,
                               input logic [3:0] expBe, input logic [31:0] expWd);
    int   g;
    int   r;
    int   doneCyc;
    logic reqExp;
    exp_t e;
    g       = 1 + gntExtra;
    r       = g + rvLat;
    doneCyc = expErr ? 1 : r + 1;
    e.rdata = expRd;
    e.mis   = expErr;
    sbQ.push_back(e);
    for (int c = 0; c <= doneCyc; c++) begin
      @(negedge clk);
      if (c == 0) begin
        ls_valid  = 1'b1;
        ls_write  = wr;
        ls_funct3 = f3;
        ls_addr   = addr;
        ls_wdata  = wd;
      end else begin
        ls_write  = 1'($urandom);
        ls_funct3 = 3'($urandom);
        ls_addr   = $urandom;
        ls_wdata  = $urandom;
      end
      mem_gnt    = !expErr && (c == g);
      mem_rvalid = !expErr && (c == r);
      mem_rdata  = (c == r) ? memData : $urandom;
      #1;
      reqExp = !expErr && (c >= 1) && (c <= g);
      checkOutput({name, " stall"}, 32'(ls_stall), 32'(c < doneCyc));
      checkOutput({name, " done"}, 32'(ls_done), 32'(c == doneCyc));
      checkOutput({name, " mem_req"}, 32'(mem_req), 32'(reqExp));
      if (reqExp) begin
        checkOutput({name, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        checkOutput({name, " mem_be"}, 32'(mem_be), 32'(expBe));
        checkOutput({name, " mem_we"}, 32'(mem_we), 32'(wr));
        if (wr) checkOutput({name, " mem_wdata"}, mem_wdata, expWd);
      end
      if (c == doneCyc) begin
        e = sbQ.pop_front();
        checkOutput({name, " rdata"}, ls_rdata, e.rdata);
        checkOutput({name, " misaligned"}, 32'(ls_misaligned), 32'(e.mis));
      end
    end
    @(negedge clk);
    ls_valid   = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    checkOutput({name, " idle stall"}, 32'(ls_stall), 32'd0);
  endtask

  initial begin
    reset      = 1'b0;
    ls_valid   = 1'b0;
    ls_write   = 1'b0;
    ls_funct3  = 3'b000;
    ls_addr    = 32'h0;
    ls_wdata   = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset stall", 32'(ls_stall), 32'd0);
    checkOutput("reset done", 32'(ls_done), 32'd0);
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset rdata", ls_rdata, 32'd0);
    checkOutput("reset mem_be", 32'(mem_be), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    //            name    wr    f3      addr          wdata         memData       gx rl err expRd         be       expWd
    applyStimulus("sw",   1'b1, 3'b010, 32'h00000100, 32'hDEADBEEF, 32'h0,        0, 1, 0, 32'h00000000, 4'b1111, 32'hDEADBEEF);
    applyStimulus("lb",   1'b0, 3'b000, 32'h00000103, 32'h0,        32'h80112233, 0, 1, 0, 32'hFFFFFF80, 4'b1000, 32'h0);
    applyStimulus("lbu",  1'b0, 3'b100, 32'h00000103, 32'h0,        32'h80112233, 0, 1, 0, 32'h00000080, 4'b1000, 32'h0);
    applyStimulus("lh",   1'b0, 3'b001, 32'h00000102, 32'h0,        32'h80012233, 0, 1, 0, 32'hFFFF8001, 4'b1100, 32'h0);
    applyStimulus("sh",   1'b1, 3'b001, 32'h00000102, 32'h0000ABCD, 32'h0,        0, 1, 0, 32'h00000000, 4'b1100, 32'hABCDABCD);
    applyStimulus("lw_mis", 1'b0, 3'b010, 32'h00000102, 32'h0,      32'h0,        0, 1, 1, 32'h00000000, 4'b0000, 32'h0);
    applyStimulus("l_f3_011", 1'b0, 3'b011, 32'h00000100, 32'h0,    32'h0,        0, 1, 1, 32'h00000000, 4'b0000, 32'h0);
    applyStimulus("lhu_slow", 1'b0, 3'b101, 32'h00000200, 32'h0,    32'h1234F00D, 3, 2, 0, 32'h0000F00D, 4'b0011, 32'h0);
    applyStimulus("sb",   1'b1, 3'b000, 32'h00000101, 32'h1234565A, 32'h0,        0, 1, 0, 32'h00000000, 4'b0010, 32'h5A5A5A5A);
    applyStimulus("lw",   1'b0, 3'b010, 32'h00000108, 32'h0,        32'hCAFEF00D, 1, 3, 0, 32'hCAFEF00D, 4'b1111, 32'h0);
    applyStimulus("lh_lo", 1'b0, 3'b001, 32'h00000300, 32'h0,       32'h8001_7FFE, 0, 1, 0, 32'h00007FFE, 4'b0011, 32'h0);
    applyStimulus("sbu_ill", 1'b1, 3'b100, 32'h00000100, 32'h0,     32'h0,        0, 1, 1, 32'h00000000, 4'b0000, 32'h0);
    applyStimulus("sh_mis", 1'b1, 3'b001, 32'h00000101, 32'h0,      32'h0,        0, 1, 1, 32'h00000000, 4'b0000, 32'h0);

    // Reset while waiting for the response: the transaction is abandoned,
    // everything reads zero, and a late rvalid must not complete anything.
    @(negedge clk);
    ls_valid  = 1'b1;
    ls_write  = 1'b0;
    ls_funct3 = 3'b010;
    ls_addr   = 32'h00000104;
    @(negedge clk);
    mem_gnt = 1'b1;
    #1;
    checkOutput("rst_wait mem_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    mem_gnt = 1'b0;
    reset   = 1'b0;
    #1;
    checkOutput("rst_wait in WAIT mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    reset      = 1'b1;
    ls_valid   = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55AA55AA;
    #1;
    checkOutput("rst_wait stall", 32'(ls_stall), 32'd0);
    checkOutput("rst_wait done", 32'(ls_done), 32'd0);
    checkOutput("rst_wait mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_wait mem_addr", mem_addr, 32'd0);
    checkOutput("rst_wait rdata", ls_rdata, 32'd0);
    checkOutput("rst_wait misaligned", 32'(ls_misaligned), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rvalid = (i == 0);
      #1;
      checkOutput("stray rvalid done", 32'(ls_done), 32'd0);
      checkOutput("stray rvalid rdata", ls_rdata, 32'd0);
    end
    mem_rvalid = 1'b0;

    if (sbQ.size() != 0) begin
      nChecks++;
      nFail++;
      $error("[TB] FAIL scoreboard: observed %0d leftover entries expected 0", sbQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
